mandelbrot_lane_scheduler: RTL and testbench

// - Multi-lane successor to the single-set render controller. Hands raster-order pixel

---
 rtl/mandelbrot_lane_scheduler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mandelbrot_lane_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_lane_scheduler.sv
// mandelbrot_lane_scheduler: hands raster-order pixel coordinates to NUM_LANES independent
// point-generator lanes, collects their out-of-order results in a reorder buffer and streams
// them out strictly in raster order over valid/ready.
// Optional build macro: MANDEL_FRAME_PERF_EN adds frame_cycles/stall_cycles counters.
module mandelbrot_lane_scheduler #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned ITER_W    = 32,
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned COORD_W   = 11
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [COORD_W-1:0]           x_size,
  input  logic [COORD_W-1:0]           y_size,
  output logic [NUM_LANES-1:0]         lane_go,
  output logic [NUM_LANES*COORD_W-1:0] lane_x,
  output logic [NUM_LANES*COORD_W-1:0] lane_y,
  input  logic [NUM_LANES-1:0]         lane_done,
  input  logic [NUM_LANES*ITER_W-1:0]  lane_iter,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ITER_W-1:0]            out_data,
  output logic                         out_last,
  output logic                         busy,
`ifdef MANDEL_FRAME_PERF_EN
  output logic [31:0]                  frame_cycles,
  output logic [31:0]                  stall_cycles,
`endif
  output logic                         frame_done
);

  localparam int unsigned IdxW  = 2 * COORD_W;
  localparam int unsigned TagW  = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StAbort} state_e;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_size_q, x_size_d;
  logic [IdxW-1:0]     total_q, total_d;
  logic [IdxW-1:0]     issue_idx_q, issue_idx_d;
  logic [IdxW-1:0]     out_idx_q, out_idx_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic                frame_done_q, frame_done_d;
  logic [ROB_DEPTH-1:0] rob_valid_q, rob_valid_d;
  logic                rob_clear;

  logic [NUM_LANES-1:0] lane_busy_q;
  logic [NUM_LANES-1:0] lane_go_q;
  logic [COORD_W-1:0]   lane_x_q   [NUM_LANES];
  logic [COORD_W-1:0]   lane_y_q   [NUM_LANES];
  logic [TagW-1:0]      lane_tag_q [NUM_LANES];
  logic [ITER_W-1:0]    rob_data_q [ROB_DEPTH];

  logic [NUM_LANES-1:0] lane_avail;
  logic [LaneW-1:0]     issue_lane;
  logic                 lane_free_any;
  logic [IdxW-1:0]      occupancy;
  logic                 rob_full;
  logic                 issue_en;
  logic [TagW-1:0]      issue_tag;
  logic [TagW-1:0]      out_tag;
  logic                 out_active;
  logic                 rob_wr_en;
  logic                 handshake;
  logic                 x_last;

  // A lane finishing this cycle can be handed a new pixel in the same decision.
  assign lane_avail = ~lane_busy_q | lane_done;
  // Full-width subtraction so the occupancy compare survives index wrap.
  assign occupancy  = issue_idx_q - out_idx_q;
  assign rob_full   = occupancy >= IdxW'(ROB_DEPTH);
  assign issue_en   = (state_q == StIssue) && !abort && (issue_idx_q != total_q) &&
                      !rob_full && lane_free_any;
  assign issue_tag  = TagW'(issue_idx_q & IdxW'(ROB_DEPTH - 1));
  assign out_tag    = TagW'(out_idx_q & IdxW'(ROB_DEPTH - 1));
  assign out_active = (state_q == StIssue) || (state_q == StDrain);
  assign rob_wr_en  = out_active;
  assign x_last     = (x_q == x_size_q - COORD_W'(1));

  assign out_valid  = out_active && rob_valid_q[out_tag];
  assign out_data   = out_valid ? rob_data_q[out_tag] : '0;
  assign out_last   = out_active && (out_idx_q == total_q - IdxW'(1));
  assign handshake  = out_valid && out_ready;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign lane_go    = lane_go_q;

  for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane_out
    assign lane_x[g*COORD_W +: COORD_W] = lane_x_q[g];
    assign lane_y[g*COORD_W +: COORD_W] = lane_y_q[g];
  end

  // Pick the lowest-numbered lane that is free (or freeing) this cycle.
  always_comb begin
    issue_lane    = '0;
    lane_free_any = 1'b0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (lane_avail[i]) begin
        issue_lane    = LaneW'(i);
        lane_free_any = 1'b1;
      end
    end
  end

  // Frame FSM plus issue/output index bookkeeping.
  always_comb begin
    state_d      = state_q;
    x_size_d     = x_size_q;
    total_d      = total_q;
    issue_idx_d  = issue_idx_q;
    out_idx_d    = out_idx_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    rob_clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (x_size == '0 || y_size == '0) begin
            frame_done_d = 1'b1;
          end else begin
            state_d     = StIssue;
            x_size_d    = x_size;
            total_d     = IdxW'(x_size) * IdxW'(y_size);
            issue_idx_d = '0;
            out_idx_d   = '0;
            x_d         = '0;
            y_d         = '0;
          end
        end
      end
      StIssue: begin
        if (abort)                         state_d = StAbort;
        else if (issue_idx_q == total_q)   state_d = StDrain;
      end
      StDrain: begin
        if (abort) begin
          state_d = StAbort;
        end else if (out_idx_q == total_q) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      StAbort: begin
        // Results of in-flight lanes are dropped; leave only once every lane is idle.
        if (lane_busy_q == '0) begin
          state_d     = StIdle;
          rob_clear   = 1'b1;
          issue_idx_d = '0;
          out_idx_d   = '0;
          total_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (issue_en) begin
      issue_idx_d = issue_idx_q + IdxW'(1);
      if (x_last) begin
        x_d = '0;
        y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
    if (handshake) out_idx_d = out_idx_q + IdxW'(1);
  end

  // ROB valid bits: drain clears the head, lane completions set their tags.
  always_comb begin
    rob_valid_d = rob_valid_q;
    if (handshake) rob_valid_d[out_tag] = 1'b0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (rob_wr_en && lane_done[i] && lane_busy_q[i]) rob_valid_d[lane_tag_q[i]] = 1'b1;
    end
    if (rob_clear) rob_valid_d = '0;
  end

  // Control state registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      x_size_q     <= '0;
      total_q      <= '0;
      issue_idx_q  <= '0;
      out_idx_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      rob_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      x_size_q     <= x_size_d;
      total_q      <= total_d;
      issue_idx_q  <= issue_idx_d;
      out_idx_q    <= out_idx_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      rob_valid_q  <= rob_valid_d;
    end
  end

  // Per-lane issue registers and ROB data capture.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      lane_busy_q <= '0;
      lane_go_q   <= '0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        lane_x_q[i]   <= '0;
        lane_y_q[i]   <= '0;
        lane_tag_q[i] <= '0;
      end
      for (int e = 0; e < int'(ROB_DEPTH); e++) rob_data_q[e] <= '0;
    end else begin
      lane_go_q <= '0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (lane_done[i]) lane_busy_q[i] <= 1'b0;
        if (rob_wr_en && lane_done[i] && lane_busy_q[i]) begin
          rob_data_q[lane_tag_q[i]] <= lane_iter[i*ITER_W +: ITER_W];
        end
      end
      if (issue_en) begin
        lane_go_q[issue_lane]   <= 1'b1;
        lane_busy_q[issue_lane] <= 1'b1;
        lane_x_q[issue_lane]    <= x_q;
        lane_y_q[issue_lane]    <= y_q;
        lane_tag_q[issue_lane]  <= issue_tag;
      end
    end
  end

`ifdef MANDEL_FRAME_PERF_EN
  logic        stall;
  logic [31:0] run_cycles_q, run_stalls_q, frame_cycles_q, stall_cycles_q;

  assign stall        = (state_q == StIssue) && !abort && (issue_idx_q != total_q) && rob_full;
  assign frame_cycles = frame_cycles_q;
  assign stall_cycles = stall_cycles_q;

  // Running per-frame counters, published only when a frame completes.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      run_cycles_q   <= '0;
      run_stalls_q   <= '0;
      frame_cycles_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        run_cycles_q <= 32'd1;
        run_stalls_q <= '0;
      end else begin
        if (busy && run_cycles_q != '1) run_cycles_q <= run_cycles_q + 32'd1;
        if (stall && run_stalls_q != '1) run_stalls_q <= run_stalls_q + 32'd1;
      end
      if (frame_done_d) begin
        frame_cycles_q <= (state_q == StIdle) ? 32'd1 : run_cycles_q;
        stall_cycles_q <= (state_q == StIdle) ? 32'd0 : run_stalls_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mandelbrot_lane_scheduler.sv
// Bench for mandelbrot_lane_scheduler: a table of frames run through a lane model with a
// raster-order scoreboard, plus hand sequences for ROB full, abort and mid-frame reset.
`timescale 1ns/1ps
module tb_mandelbrot_lane_scheduler;
  localparam int unsigned NumLanes = 4;
  localparam int unsigned IterW    = 32;
  localparam int unsigned RobDepth = 4;
  localparam int unsigned CoordW   = 11;

  logic                        CLK = 1'b0;
  logic                        reset = 1'b1;
  logic                        start = 1'b0;
  logic                        abort = 1'b0;
  logic [CoordW-1:0]           x_size = '0;
  logic [CoordW-1:0]           y_size = '0;
  logic [NumLanes-1:0]         lane_go;
  logic [NumLanes*CoordW-1:0]  lane_x;
  logic [NumLanes*CoordW-1:0]  lane_y;
  logic [NumLanes-1:0]         lane_done = '0;
  logic [NumLanes*IterW-1:0]   lane_iter = '0;
  logic                        out_valid;
  logic                        out_ready = 1'b0;
  logic [IterW-1:0]            out_data;
  logic                        out_last;
  logic                        busy;
  logic                        frame_done;
`ifdef MANDEL_FRAME_PERF_EN
  logic [31:0]                 frame_cycles;
  logic [31:0]                 stall_cycles;
`endif

  always #5 CLK = ~CLK;

  mandelbrot_lane_scheduler #(
    .NUM_LANES(NumLanes), .ITER_W(IterW), .ROB_DEPTH(RobDepth), .COORD_W(CoordW)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .x_size(x_size), .y_size(y_size),
    .lane_go(lane_go), .lane_x(lane_x), .lane_y(lane_y),
    .lane_done(lane_done), .lane_iter(lane_iter),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy),
`ifdef MANDEL_FRAME_PERF_EN
    .frame_cycles(frame_cycles), .stall_cycles(stall_cycles),
`endif
    .frame_done(frame_done)
  );

  typedef struct { logic [IterW-1:0] data; logic last; } exp_t;
  typedef struct { int xs; int ys; int lmode; int rmode; int outs; int fds; int gos; } vec_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int cur_xs = 1;
  int cur_salt = 0;
  int lane_mode = 0;
  int ready_mode = 0;
  int go_idx = 0, go_cnt = 0, out_cnt = 0, fd_cnt = 0, busy_cnt = 0;
  int first_go_cyc = -1, start_cyc = 0;
  int valid_after_abort = 0;
  bit abort_mon = 1'b0;
  int lane_cnt [NumLanes];
  logic [IterW-1:0] lane_res [NumLanes];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int lane_delay(input int i);
    case (lane_mode)
      1:       return 10 - 3 * i;  // lane 3 replies first
      2:       return 2;
      3:       return 6;
      default: return 3;
    endcase
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Lane model: each go starts a countdown; result = salt + raster index of the coordinates.
  initial begin
    int lx, ly, xs;
    for (int i = 0; i < NumLanes; i++) lane_cnt[i] = 0;
    forever begin
      @(posedge CLK); #1;
      lane_done = '0;
      if (reset) begin
        for (int i = 0; i < NumLanes; i++) lane_cnt[i] = 0;
      end else begin
        for (int i = 0; i < NumLanes; i++) begin
          if (lane_cnt[i] > 0) begin
            lane_cnt[i]--;
            if (lane_cnt[i] == 0) begin
              lane_done[i] = 1'b1;
              lane_iter[i*IterW +: IterW] = lane_res[i];
            end
          end
        end
        if (lane_go != '0) check("one_go_per_cycle", 64'($countones(lane_go)), 64'd1);
        xs = (cur_xs == 0) ? 1 : cur_xs;
        for (int i = 0; i < NumLanes; i++) begin
          if (lane_go[i]) begin
            lx = int'(lane_x[i*CoordW +: CoordW]);
            ly = int'(lane_y[i*CoordW +: CoordW]);
            check("go_x", 64'(lx), 64'(go_idx % xs));
            check("go_y", 64'(ly), 64'(go_idx / xs));
            lane_res[i] = IterW'(cur_salt + ly * xs + lx);
            lane_cnt[i] = lane_delay(i);
            if (first_go_cyc < 0) first_go_cyc = cyc;
            go_idx++;
            go_cnt++;
          end
        end
      end
    end
  end

  // Sink ready pattern.
  initial begin
    forever begin
      @(posedge CLK); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pops on handshake, held data must stay stable.
  bit held = 1'b0;
  logic [IterW-1:0] held_data = '0;
  exp_t e;
  always @(negedge CLK) begin
    if (!reset) begin
      if (frame_done) fd_cnt++;
      if (busy) busy_cnt++;
      if (abort_mon && out_valid) valid_after_abort++;
      if (held && out_valid) check("out_data_stable", 64'(out_data), 64'(held_data));
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_last", 64'(out_last), 64'(e.last));
        end
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
    end else begin
      held = 1'b0;
    end
  end

  task automatic run_frame(input int xs, input int ys, input int salt);
    int total;
    cur_xs = xs;
    cur_salt = salt;
    go_idx = 0;
    first_go_cyc = -1;
    total = xs * ys;
    for (int p = 0; p < total; p++) begin
      exp_t x;
      x.data = IterW'(salt + p);
      x.last = (p == total - 1);
      sb.push_back(x);
    end
    @(posedge CLK); #1;
    x_size = CoordW'(xs);
    y_size = CoordW'(ys);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int fd0, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge CLK); #1;
      if (fd_cnt != fd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    int out0, fd0, go0, busy0, go_at;
    bit ok;
    vecs[0] = '{4, 2, 0, 0, 8, 1, 8};
    vecs[1] = '{4, 2, 1, 0, 8, 1, 8};
    vecs[2] = '{3, 3, 0, 1, 9, 1, 9};
    vecs[3] = '{0, 5, 0, 0, 0, 1, 0};
    vecs[4] = '{5, 0, 0, 0, 0, 1, 0};
    vecs[5] = '{1, 1, 2, 0, 1, 1, 1};
    vecs[6] = '{5, 3, 1, 1, 15, 1, 15};

    // Reset state.
    #12;
    check("rst_lane_go", 64'(lane_go), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge CLK); #1;
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      lane_mode  = vecs[v].lmode;
      ready_mode = vecs[v].rmode;
      out0 = out_cnt; fd0 = fd_cnt; go0 = go_cnt; busy0 = busy_cnt;
      run_frame(vecs[v].xs, vecs[v].ys, 256 * (v + 1));
      wait_done(fd0, 1000, ok);
      check($sformatf("v%0d_frame_done_seen", v), 64'(ok), 64'd1);
      repeat (5) @(posedge CLK);
      #1;
      if (v == 0) check("issue_latency", 64'(first_go_cyc - start_cyc), 64'd2);
      check($sformatf("v%0d_outputs", v), 64'(out_cnt - out0), 64'(vecs[v].outs));
      check($sformatf("v%0d_frame_dones", v), 64'(fd_cnt - fd0), 64'(vecs[v].fds));
      check($sformatf("v%0d_lane_gos", v), 64'(go_cnt - go0), 64'(vecs[v].gos));
      check($sformatf("v%0d_sb_empty", v), 64'(sb.size()), 64'd0);
      check($sformatf("v%0d_busy_low", v), 64'(busy), 64'd0);
      if (vecs[v].gos == 0) check($sformatf("v%0d_never_busy", v), 64'(busy_cnt - busy0), 64'd0);
      sb.delete();
    end

    // ROB full: sink stalled, only RobDepth pixels may be issued.
    lane_mode = 2; ready_mode = 2;
    out0 = out_cnt; fd0 = fd_cnt; go0 = go_cnt;
    run_frame(4, 2, 32'h1000);
    repeat (20) @(posedge CLK);
    #1;
    check("robfull_gos", 64'(go_cnt - go0), 64'(RobDepth));
    check("robfull_valid", 64'(out_valid), 64'd1);
    check("robfull_head", 64'(out_data), 64'h1000);
    check("robfull_busy", 64'(busy), 64'd1);
    ready_mode = 0;
    wait_done(fd0, 1000, ok);
    check("robfull_done_seen", 64'(ok), 64'd1);
    repeat (3) @(posedge CLK);
    #1;
    check("robfull_outputs", 64'(out_cnt - out0), 64'd8);
    check("robfull_total_gos", 64'(go_cnt - go0), 64'd8);
    check("robfull_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();

    // Abort after 5 issues while lanes are still working.
    lane_mode = 3; ready_mode = 0;
    fd0 = fd_cnt; go0 = go_cnt;
    run_frame(4, 2, 32'h2000);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (go_cnt - go0 >= 5) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    check("abort_five_issued", 64'(ok), 64'd1);
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    abort_mon = 1'b1;
    go_at = go_cnt;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge CLK); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_busy_fell", 64'(ok), 64'd1);
    check("abort_lanes_idle", 64'(lane_cnt[0] + lane_cnt[1] + lane_cnt[2] + lane_cnt[3]), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    abort_mon = 1'b0;
    check("abort_no_go", 64'(go_cnt), 64'(go_at));
    check("abort_valid_low", 64'(valid_after_abort), 64'd0);
    check("abort_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
    sb.delete();

    // Clean frame after abort.
    lane_mode = 1;
    out0 = out_cnt; fd0 = fd_cnt;
    run_frame(2, 2, 32'h2800);
    wait_done(fd0, 500, ok);
    check("post_abort_done_seen", 64'(ok), 64'd1);
    repeat (3) @(posedge CLK);
    #1;
    check("post_abort_outputs", 64'(out_cnt - out0), 64'd4);
    check("post_abort_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();

    // Asynchronous reset mid-frame.
    lane_mode = 3; ready_mode = 2;
    run_frame(4, 2, 32'h3000);
    repeat (4) @(posedge CLK);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_lane_go", 64'(lane_go), 64'd0);
    check("mid_rst_lane_x", 64'(lane_x), 64'd0);
    check("mid_rst_lane_y", 64'(lane_y), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_out_last", 64'(out_last), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_frame_done", 64'(frame_done), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    sb.delete();
    lane_mode = 0; ready_mode = 0;
    out0 = out_cnt; fd0 = fd_cnt; go0 = go_cnt;
    run_frame(2, 2, 32'h4000);
    wait_done(fd0, 500, ok);
    check("post_rst_done_seen", 64'(ok), 64'd1);
    repeat (3) @(posedge CLK);
    #1;
    check("post_rst_outputs", 64'(out_cnt - out0), 64'd4);
    check("post_rst_gos", 64'(go_cnt - go0), 64'd4);
    check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
